// File: rtl/shift_seq_rev.sv
// shift_seq_rev: multi-cycle SRL / ROL shifter with a start/ready/done handshake.
// Shifts one bit per clock edge by default.
// Optional macro SHIFT_SEQ_NIBBLE_STEP_EN: while at least 4 bits remain, each edge
// moves 4 bits at once, then the block finishes with 1-bit steps. Results are
// identical to the 1-bit mode; only the latency differs.
module shift_seq_rev #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Start,
    input  logic [WIDTH-1:0]   Shift_In,
    input  logic [SHAMT_W-1:0] Shift_Val,
    input  logic               Mode,
    output logic               Ready,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   Shift_Out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] count;
    logic               mode_q;

    // Single-bit step: Mode 0 = logical right (zero fill at MSB), 1 = rotate left
    function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] r, input logic m);
        if (m)
            return {r[WIDTH-2:0], r[WIDTH-1]};
        else
            return {1'b0, r[WIDTH-1:1]};
    endfunction

`ifdef SHIFT_SEQ_NIBBLE_STEP_EN
    // Four-bit step, equivalent to four consecutive single-bit steps
    function automatic logic [WIDTH-1:0] step4(input logic [WIDTH-1:0] r, input logic m);
        if (m)
            return {r[WIDTH-5:0], r[WIDTH-1:WIDTH-4]};
        else
            return {4'b0000, r[WIDTH-1:4]};
    endfunction
`endif

    // The work register drives the result directly; partial values are visible during SHIFT
    assign Shift_Out = work;

    // Control FSM plus datapath; handshake outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            count  <= '0;
            mode_q <= 1'b0;
            Ready  <= 1'b1;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        work   <= Shift_In;
                        count  <= Shift_Val;
                        mode_q <= Mode;
                        if (Shift_Val != '0) begin
                            state <= SHIFT;
                            Ready <= 1'b0;
                            Busy  <= 1'b1;
                            Done  <= 1'b0;
                        end else begin
                            state <= DONE;
                            Ready <= 1'b1;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        Ready <= 1'b1;
                        Busy  <= 1'b0;
                        Done  <= 1'b0;
                    end
                end
                SHIFT: begin
`ifdef SHIFT_SEQ_NIBBLE_STEP_EN
                    if (count >= SHAMT_W'(4)) begin
                        work  <= step4(work, mode_q);
                        count <= count - SHAMT_W'(4);
                        if (count == SHAMT_W'(4)) begin
                            state <= DONE;
                            Ready <= 1'b1;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end
                    end else begin
                        work  <= step1(work, mode_q);
                        count <= count - SHAMT_W'(1);
                        if (count == SHAMT_W'(1)) begin
                            state <= DONE;
                            Ready <= 1'b1;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end
                    end
`else
                    work  <= step1(work, mode_q);
                    count <= count - SHAMT_W'(1);
                    if (count == SHAMT_W'(1)) begin
                        state <= DONE;
                        Ready <= 1'b1;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    Ready <= 1'b1;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_rev.sv
// tb_shift_seq_rev: scoreboard bench for shift_seq_rev (directed cases + random requests).
module tb_shift_seq_rev;

    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               Start;
    logic [WIDTH-1:0]   Shift_In;
    logic [SHAMT_W-1:0] Shift_Val;
    logic               Mode;
    logic               Ready;
    logic               Busy;
    logic               Done;
    logic [WIDTH-1:0]   Shift_Out;

    shift_seq_rev #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk(clk), .rst(rst), .Start(Start), .Shift_In(Shift_In),
        .Shift_Val(Shift_Val), .Mode(Mode), .Ready(Ready), .Busy(Busy),
        .Done(Done), .Shift_Out(Shift_Out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] val;
        int               due;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: result of shifting x by n under the given mode
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] x, input int n, input logic m);
        logic [2*WIDTH-1:0] dbl;
        if (m) begin
            dbl = {x, x} << n;
            return dbl[2*WIDTH-1:WIDTH];
        end
        return x >> n;
    endfunction

    // Reference: number of clock edges between accept and Done
    function automatic int ref_edges(input int n);
`ifdef SHIFT_SEQ_NIBBLE_STEP_EN
        return (n >> 2) + (n & 3);
`else
        return n;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever Done is seen
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            check("ready_not_busy", {31'd0, Ready}, {31'd0, ~Busy});
            if (Done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", {16'd0, Shift_Out}, {16'd0, e.val});
                    check("done_cycle", cyc, e.due);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge
    task automatic do_req(input logic [WIDTH-1:0] x, input int n, input logic m);
        exp_t e;
        int   guard;
        guard = 0;
        while (Ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (Ready !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
        Start     = 1'b1;
        Shift_In  = x;
        Shift_Val = SHAMT_W'(n);
        Mode      = m;
        e.val = ref_shift(x, n, m);
        e.due = cyc + 1 + ref_edges(n);
        exp_q.push_back(e);
        @(negedge clk);
        Start     = 1'b0;
        Shift_In  = WIDTH'($urandom);
        Shift_Val = SHAMT_W'($urandom);
        Mode      = 1'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; Start = 1'b0; Shift_In = '0; Shift_Val = '0; Mode = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", {31'd0, Ready}, 32'd1);
        check("reset_busy",  {31'd0, Busy},  32'd0);
        check("reset_done",  {31'd0, Done},  32'd0);
        check("reset_out",   {16'd0, Shift_Out}, 32'h0000);

        // Directed cases
        do_req(16'h8001, 1, 1'b0);
        check("srl_busy", {31'd0, Busy}, 32'd1);
        drain();
        do_req(16'h1234, 4, 1'b1);
        drain();
        // Zero shift followed by a back-to-back SRL by 15 issued in the Done cycle
        do_req(16'hABCD, 0, 1'b0);
        check("zero_ready", {31'd0, Ready}, 32'd1);
        do_req(16'hF000, 15, 1'b0);
        drain();
        // Start during a shift must be ignored
        do_req(16'h8000, 7, 1'b1);
        @(negedge clk);
        Start = 1'b1; Shift_In = 16'hFFFF; Shift_Val = 4'd3; Mode = 1'b0;
        check("busy_not_ready", {31'd0, Ready}, 32'd0);
        @(negedge clk);
        Start = 1'b0;
        drain();
        // Reset three edges into an SRL by 10
        do_req(16'hFFFF, 10, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", {31'd0, Ready}, 32'd1);
        check("abort_busy",  {31'd0, Busy},  32'd0);
        check("abort_done",  {31'd0, Done},  32'd0);
        check("abort_out",   {16'd0, Shift_Out}, 32'h0000);
        do_req(16'h00F0, 3, 1'b1);
        drain();
        // Boundary: width-1 shifts
        do_req(16'h8421, 15, 1'b1);
        drain();
        do_req(16'h8000, 15, 1'b0);
        drain();

        // Random requests, sometimes back-to-back
        for (int i = 0; i < 60; i++) begin
            do_req(WIDTH'($urandom), int'($urandom_range(0, WIDTH - 1)), 1'($urandom));
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_seq_rev.md
Name: shift_seq_rev

Overview:
- Multi-cycle, one-bit-per-cycle shifter for the shift directions the combinational ALU shifter does not provide: logical right shift (SRL) and rotate left (ROL).
- Sits beside the ALU shifter in the execute stage and serves the SRL/ROL instruction extensions.
- Uses a start/ready/done handshake so the pipeline stalls while the shift is in progress.

Parameters:
- WIDTH, 16, data width in bits.
- SHAMT_W, 4, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only when Ready=1.
- Shift_In  input  WIDTH  operand; captured on the accept edge.
- Shift_Val  input  SHAMT_W  shift amount 0..WIDTH-1; captured on the accept edge.
- Mode  input  1  0 = SRL (zero fill from the MSB side), 1 = ROL (MSB wraps into the LSB).
- Ready  output  1  high when a new request can be accepted.
- Busy  output  1  high while in the SHIFT state.
- Done  output  1  one-cycle pulse marking Shift_Out as valid.
- Shift_Out  output  WIDTH  result register.

Behaviour:
- Interface: one clock, clk; synchronous, active-high reset, rst.
- States:
  - IDLE: Ready=1, Busy=0, Done=0.
  - SHIFT: Ready=0, Busy=1, Done=0.
  - DONE: Ready=1, Busy=0, Done=1.
- Reset: state=IDLE, Shift_Out=0, Done=0, Busy=0, Ready=1, internal count=0.
- Reset mid-operation aborts the shift. No Done is produced for the aborted request.
- Accept edge: Start=1 and Ready=1 at a rising edge.
  - Shift_In is loaded into the work register, which drives Shift_Out directly.
  - count is loaded with Shift_Val and Mode is latched.
  - Next state is SHIFT if Shift_Val!=0, otherwise DONE.
- SHIFT, each edge:
  - Work register becomes {1'b0, r[WIDTH-1:1]} for SRL or {r[WIDTH-2:0], r[WIDTH-1]} for ROL.
  - count decrements.
  - If count was 1 before the edge, next state is DONE.
- Timing:
  - Done is high in the cycle after the N-th edge following the accept edge, where N=Shift_Val.
  - For N=0, Done is high in the cycle immediately after the accept edge.
  - Shift_Out is valid while Done=1 and holds until the next accept edge.
- Intermediate values: Shift_Out shows partial results during SHIFT. The consumer samples only when Done=1.
- DONE: Done lasts exactly one cycle.
  - Start=1 in DONE is accepted, allowing back-to-back operations with no bubble.
  - Otherwise the block returns to IDLE.
- Start while Busy=1 is ignored. The inputs are not sampled and the operation in progress is unaffected.
- Mode and Shift_In changing after the accept edge have no effect.
- ROL by WIDTH-1 equals rotate-right by 1. SRL by WIDTH-1 leaves only the original MSB, in bit 0.

Optional Feature:
- Macro: SHIFT_SEQ_NIBBLE_STEP_EN.
- When defined: in SHIFT, if count>=4, one edge shifts or rotates by 4 bits and count decreases by 4. Otherwise the block steps by 1 bit. Done follows (N>>2)+(N&3) edges after accept (DONE is entered on the accept edge for N=0). Results are identical to 1-bit mode.
- When undefined: 1 bit per edge only. The 4-bit datapath is not synthesized.

Test Plan:
- Reset, then hold Start=0 -> Ready=1, Busy=0, Done=0, Shift_Out=0x0000.
- SRL: Shift_In=0x8001, Shift_Val=1, Mode=0 -> Done 1 edge after accept, Shift_Out=0x4000.
- ROL: Shift_In=0x1234, Shift_Val=4, Mode=1 -> Done 4 edges after accept (1 edge with NIBBLE), Shift_Out=0x2341.
- Shift_Val=0, Shift_In=0xABCD -> Done in the cycle after accept, Shift_Out=0xABCD. Then SRL 0xF000 by 15 with Start held in the Done cycle -> accepted with no bubble, Shift_Out=0x0001 after 15 edges (6 with NIBBLE).
- During an ROL of 0x8000 by 7, pulse Start with Shift_In=0xFFFF -> the pulse is ignored, Shift_Out=0x0040, exactly one Done pulse.
- Assert rst 3 edges into SRL 0xFFFF by 10 -> next cycle state IDLE, Shift_Out=0, no Done; a new request then completes normally.
